mousetrap_sync_bridge: RTL

// Clocked endpoint joining a synchronous ready/valid domain to two-phase bundled-data MOUSETRAP channels.
// TX path: sync push -> DEPTH-entry FIFO -> two-phase ReqOut/AckOut channel.
// RX path: two-phase ReqIn/AckIn channel -> DEPTH-entry FIFO -> sync pop.

---
 rtl/mousetrap_sync_bridge_pkg.sv | 12 +
 rtl/mousetrap_sync_bridge_if.sv | 29 ++
 rtl/mousetrap_sync_bridge_fifo.sv | 52 +++++
 rtl/mousetrap_sync_bridge.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mousetrap_sync_bridge_pkg.sv
// Shared types for the MOUSETRAP sync bridge: TX FSM states and two-phase handshake phase.
package mt_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT_ACK} mt_tx_state_e;
  typedef logic mt_phase_t;

  // Two-phase channel: a token is outstanding while the phases differ.
  function automatic logic mt_pending(mt_phase_t req, mt_phase_t ack);
    return req != ack;
  endfunction

endpackage

// File: rtl/mousetrap_sync_bridge_if.sv
// Bridge boundary: sync ready/valid push/pop plus both two-phase bundled-data channels.
interface mt_bridge_if
  import mt_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  mt_phase_t        ReqOut;
  logic [WIDTH-1:0] DataOut;
  mt_phase_t        AckOut;
  mt_phase_t        ReqIn;
  logic [WIDTH-1:0] DataIn;
  mt_phase_t        AckIn;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport slave (
    input  s_valid, s_data, AckOut, ReqIn, DataIn, m_ready,
    output s_ready, ReqOut, DataOut, AckIn, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, AckOut, ReqIn, DataIn, m_ready,
    input  s_ready, ReqOut, DataOut, AckIn, m_valid, m_data
  );
endinterface

// File: rtl/mousetrap_sync_bridge_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero when empty.
module mt_bridge_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wptr_d = push_i ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_i  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    if (push_i && !pop_i)      cnt_d = cnt_q + 1'b1;
    else if (!push_i && pop_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk)
    if (push_i) mem_q[wptr_q] <= wdata_i;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push_i && full_o));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst) !(pop_i && empty_o));
endmodule

// File: rtl/mousetrap_sync_bridge.sv
// Clocked endpoint between a ready/valid domain and two-phase MOUSETRAP channels (TX and RX).
module mousetrap_sync_bridge
  import mt_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_SETUP  = 1
) (
  input logic        clk,
  input logic        rst,
  mt_bridge_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (DATA_SETUP > 1) ? $clog2(DATA_SETUP) : 1;

  logic                   rdy_q;
  logic [SYNC_STAGES-1:0] ack_sync_q, req_sync_q;
  mt_phase_t              ack_sync, req_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_q      <= 1'b0;
      ack_sync_q <= '0;
      req_sync_q <= '0;
    end else begin
      rdy_q      <= 1'b1;
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.AckOut};
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.ReqIn};
    end
  end
  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign req_sync = req_sync_q[SYNC_STAGES-1];

  // TX path
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [WIDTH-1:0] tx_head;
  logic [CW-1:0]    tx_count;

  assign bus.s_ready = rdy_q && !tx_full;
  assign tx_push     = bus.s_valid && bus.s_ready;

  mt_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .wdata_i(bus.s_data), .pop_i(tx_pop),
    .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count)
  );

  mt_tx_state_e     state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  mt_phase_t        req_q, req_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      dout_q  <= dout_d;
    end
  end

  // DataOut is loaded only in IDLE, so it stays frozen from SETUP until the ack returns.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    dout_d  = dout_q;
    tx_pop  = 1'b0;
    case (state_q)
      IDLE: if (!tx_empty) begin
        dout_d  = tx_head;
        cnt_d   = SW'(DATA_SETUP - 1);
        state_d = SETUP;
      end
      SETUP: if (cnt_q == '0) begin
        req_d   = ~req_q;
        tx_pop  = 1'b1;
        state_d = WAIT_ACK;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      WAIT_ACK: if (!mt_pending(req_q, ack_sync)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ReqOut  = req_q;
  assign bus.DataOut = dout_q;

  // RX path: withholding AckIn while full is the upstream backpressure.
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [WIDTH-1:0] rx_head;
  logic [CW-1:0]    rx_count;
  mt_phase_t        ackin_q;

  assign rx_push = mt_pending(req_sync, ackin_q) && !rx_full;
  assign rx_pop  = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk) begin
    if (!rst) ackin_q <= 1'b0;
    else      ackin_q <= ackin_q ^ rx_push;
  end

  mt_bridge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .wdata_i(bus.DataIn), .pop_i(rx_pop),
    .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count)
  );

  assign bus.AckIn   = ackin_q;
  assign bus.m_valid = !rx_empty;
  assign bus.m_data  = rx_head;

  a_tx_cnt: assert property (@(posedge clk) disable iff (!rst) tx_count <= CW'(DEPTH));
  a_rx_cnt: assert property (@(posedge clk) disable iff (!rst) rx_count <= CW'(DEPTH));
endmodule
